// File: rtl/memwb_lsu_pkg.sv
// Shared widths, data-type codes and store FSM state type for the MEM/WB load-store stage.
package memwb_lsu_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned REG_DATA_W  = 32;
  localparam int unsigned MEM_ADDR_W  = 32;
  localparam int unsigned MEM_DATA_W  = 32;
  localparam int unsigned DATA_TYPE_W = 3;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  localparam logic [DATA_TYPE_W-1:0] DT_NO = 3'd0;
  localparam logic [DATA_TYPE_W-1:0] DT_B  = 3'd1;
  localparam logic [DATA_TYPE_W-1:0] DT_H  = 3'd2;
  localparam logic [DATA_TYPE_W-1:0] DT_W  = 3'd3;
  localparam logic [DATA_TYPE_W-1:0] DT_BU = 3'd4;
  localparam logic [DATA_TYPE_W-1:0] DT_HU = 3'd5;

  typedef enum logic {
    LSU_IDLE,
    LSU_BUSY
  } lsu_state_e;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [DATA_TYPE_W-1:0] dt,
                                         input logic [1:0]             lo);
    return (((dt == DT_H) || (dt == DT_HU)) && lo[0]) ||
           ((dt == DT_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/memwb_lsu_align.sv
// Combinational lane logic: load byte/half extraction with sign/zero extension,
// store strobe generation and lane replication.
module lsu_align
  import memwb_lsu_pkg::*;
(
  input  logic [DATA_TYPE_W-1:0] i_data_type,
  input  logic [1:0]             i_ld_lo,
  input  logic [31:0]            i_rdata,
  output logic [31:0]            o_ld_data,
  input  logic [1:0]             i_st_lo,
  input  logic [31:0]            i_st_data,
  output logic [31:0]            o_st_wdata,
  output logic [3:0]             o_st_strb
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte    = i_rdata[{i_ld_lo, 3'b000} +: 8];
    w_half    = i_rdata[{i_ld_lo[1], 4'b0000} +: 16];
    o_ld_data = i_rdata;
    case (i_data_type)
      DT_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      DT_BU:   o_ld_data = {24'h0, w_byte};
      DT_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      DT_HU:   o_ld_data = {16'h0, w_half};
      default: o_ld_data = i_rdata;
    endcase
  end

  always_comb begin
    o_st_wdata = i_st_data;
    o_st_strb  = '0;
    case (i_data_type)
      DT_B: begin
        o_st_wdata = {4{i_st_data[7:0]}};
        o_st_strb  = 4'b0001 << i_st_lo;
      end
      DT_H: begin
        o_st_wdata = {2{i_st_data[15:0]}};
        o_st_strb  = 4'b0011 << i_st_lo;
      end
      DT_W: begin
        o_st_wdata = i_st_data;
        o_st_strb  = 4'hF;
      end
      default: begin
        o_st_wdata = i_st_data;
        o_st_strb  = '0;
      end
    endcase
  end

endmodule

// File: rtl/memwb_lsu.sv
// MEM/WB stage: register-file write-back with load alignment, and a req/ack store
// engine with timeout that holds upstream while busy. Option macro: MEMWB_FWD_EN.
module memwb_lsu
  import memwb_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_w_reg_enable_i,
  input  logic                   mem_w_reg_enable_i,
  input  logic [REG_ADDR_W-1:0]  w_reg_addr_i,
  input  logic [REG_DATA_W-1:0]  ex_w_reg_data_i,
  input  logic [MEM_ADDR_W-1:0]  w_mem_addr_i,
  input  logic                   w_mem_enable_i,
  input  logic [MEM_DATA_W-1:0]  w_mem_data_i,
  input  logic [DATA_TYPE_W-1:0] data_type_i,
  input  logic [1:0]             ld_addr_lo_i,
  input  logic [31:0]            r_mem_data_i,
  output logic                   bus_req_o,
  output logic [MEM_ADDR_W-1:0]  bus_addr_o,
  output logic [31:0]            bus_wdata_o,
  output logic [3:0]             bus_strb_o,
  input  logic                   bus_ack_i,
  output logic                   hold_req_o,
  output logic                   bus_err_o,
  output logic                   misalign_o,
`ifdef MEMWB_FWD_EN
  output logic                   fwd_enable_o,
  output logic [REG_ADDR_W-1:0]  fwd_addr_o,
  output logic [REG_DATA_W-1:0]  fwd_data_o,
`endif
  output logic                   w_reg_enable_o,
  output logic [REG_ADDR_W-1:0]  w_reg_addr_o,
  output logic [REG_DATA_W-1:0]  w_reg_data_o
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_bus_req;
  logic [MEM_ADDR_W-1:0] r_bus_addr;
  logic [31:0]       r_bus_wdata;
  logic [3:0]        r_bus_strb;
  logic              r_bus_err;
  logic              r_misalign;

  logic [31:0]       w_ld_data;
  logic [31:0]       w_st_wdata;
  logic [3:0]        w_st_strb;
  logic              w_ld_mis;
  logic              w_st_mis;
  logic              w_st_go;

  lsu_align u_align (
    .i_data_type (data_type_i),
    .i_ld_lo     (ld_addr_lo_i),
    .i_rdata     (r_mem_data_i),
    .o_ld_data   (w_ld_data),
    .i_st_lo     (w_mem_addr_i[1:0]),
    .i_st_data   (w_mem_data_i),
    .o_st_wdata  (w_st_wdata),
    .o_st_strb   (w_st_strb)
  );

  always_comb begin
    w_ld_mis = mem_w_reg_enable_i & is_misaligned(data_type_i, ld_addr_lo_i);
    w_st_mis = w_mem_enable_i & is_misaligned(data_type_i, w_mem_addr_i[1:0]);
    w_st_go  = (r_state == LSU_IDLE) & w_mem_enable_i & ~w_st_mis;
  end

  always_comb begin
    w_reg_enable_o = (ex_w_reg_enable_i | mem_w_reg_enable_i) &
                     (w_reg_addr_i != REG_ZERO) & ~w_ld_mis;
    w_reg_addr_o   = w_reg_addr_i;
    w_reg_data_o   = mem_w_reg_enable_i ? w_ld_data : ex_w_reg_data_i;
  end

`ifdef MEMWB_FWD_EN
  always_comb begin
    fwd_enable_o = w_reg_enable_o;
    fwd_addr_o   = w_reg_addr_o;
    fwd_data_o   = w_reg_data_o;
  end
`endif

  // Hold falls in the ack cycle itself so upstream advances on the same edge.
  always_comb begin
    hold_req_o = w_st_go | ((r_state == LSU_BUSY) & ~bus_ack_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LSU_IDLE;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_strb  <= '0;
      r_bus_err   <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_bus_err  <= 1'b0;
      r_misalign <= w_ld_mis | ((r_state == LSU_IDLE) & w_st_mis);
      case (r_state)
        LSU_IDLE: begin
          if (w_st_go) begin
            r_bus_req   <= 1'b1;
            r_bus_addr  <= {w_mem_addr_i[MEM_ADDR_W-1:2], 2'b00};
            r_bus_wdata <= w_st_wdata;
            r_bus_strb  <= w_st_strb;
            r_cnt       <= '0;
            r_state     <= LSU_BUSY;
          end
        end
        LSU_BUSY: begin
          if (bus_ack_i) begin
            r_bus_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= LSU_IDLE;
          end else if (r_cnt == TO_LAST) begin
            r_bus_req <= 1'b0;
            r_bus_err <= 1'b1;
            r_cnt     <= '0;
            r_state   <= LSU_IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_req_o   = r_bus_req;
    bus_addr_o  = r_bus_addr;
    bus_wdata_o = r_bus_wdata;
    bus_strb_o  = r_bus_strb;
    bus_err_o   = r_bus_err;
    misalign_o  = r_misalign;
  end

endmodule

// File: tb/tb_memwb_lsu.sv
// Directed self-checking bench for memwb_lsu: load extraction, write-back select,
// store handshake, timeout, misalignment and asynchronous reset during a store.
module tb_memwb_lsu;
  import memwb_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_w_reg_enable_i, mem_w_reg_enable_i;
  logic [4:0]  w_reg_addr_i;
  logic [31:0] ex_w_reg_data_i, w_mem_addr_i, w_mem_data_i, r_mem_data_i;
  logic        w_mem_enable_i;
  logic [2:0]  data_type_i;
  logic [1:0]  ld_addr_lo_i;
  logic        bus_req_o, bus_ack_i, hold_req_o, bus_err_o, misalign_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_strb_o;
  logic        w_reg_enable_o;
  logic [4:0]  w_reg_addr_o;
  logic [31:0] w_reg_data_o;

  int n_cmp = 0;
  int n_bad = 0;

  memwb_lsu #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ex_w_reg_enable_i  (ex_w_reg_enable_i),
    .mem_w_reg_enable_i (mem_w_reg_enable_i),
    .w_reg_addr_i       (w_reg_addr_i),
    .ex_w_reg_data_i    (ex_w_reg_data_i),
    .w_mem_addr_i       (w_mem_addr_i),
    .w_mem_enable_i     (w_mem_enable_i),
    .w_mem_data_i       (w_mem_data_i),
    .data_type_i        (data_type_i),
    .ld_addr_lo_i       (ld_addr_lo_i),
    .r_mem_data_i       (r_mem_data_i),
    .bus_req_o          (bus_req_o),
    .bus_addr_o         (bus_addr_o),
    .bus_wdata_o        (bus_wdata_o),
    .bus_strb_o         (bus_strb_o),
    .bus_ack_i          (bus_ack_i),
    .hold_req_o         (hold_req_o),
    .bus_err_o          (bus_err_o),
    .misalign_o         (misalign_o),
`ifdef MEMWB_FWD_EN
    .fwd_enable_o       (),
    .fwd_addr_o         (),
    .fwd_data_o         (),
`endif
    .w_reg_enable_o     (w_reg_enable_o),
    .w_reg_addr_o       (w_reg_addr_o),
    .w_reg_data_o       (w_reg_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ex_w_reg_enable_i  = 1'b0;
    mem_w_reg_enable_i = 1'b0;
    w_reg_addr_i       = '0;
    ex_w_reg_data_i    = '0;
    w_mem_addr_i       = '0;
    w_mem_enable_i     = 1'b0;
    w_mem_data_i       = '0;
    data_type_i        = DT_NO;
    ld_addr_lo_i       = 2'b00;
    r_mem_data_i       = '0;
    bus_ack_i          = 1'b0;
  endtask

  task automatic load(input logic [2:0] dt, input logic [1:0] lo, input logic [4:0] rd);
    set_idle();
    mem_w_reg_enable_i = 1'b1;
    data_type_i        = dt;
    ld_addr_lo_i       = lo;
    w_reg_addr_i       = rd;
    r_mem_data_i       = 32'h80FF_1234;
    #1;
  endtask

  // Word store left waiting for an ack; returns BUSY cycles seen before the error pulse.
  task automatic run_timeout(input logic [31:0] addr, output int busy, output bit err);
    set_idle();
    w_mem_enable_i = 1'b1;
    w_mem_addr_i   = addr;
    w_mem_data_i   = 32'h1122_3344;
    data_type_i    = DT_W;
    #1;
    chk("to_hold_idle", {31'b0, hold_req_o}, 32'd1);
    busy = 0;
    err  = 1'b0;
    for (int k = 0; k < 40 && !err; k++) begin
      cyc();
      if (bus_err_o) err = 1'b1;
      else if (bus_req_o) busy++;
      if (k == 0) begin
        chk("sw_addr", bus_addr_o, addr);
        chk("sw_strb", {28'b0, bus_strb_o}, 32'hF);
        chk("sw_wdata", bus_wdata_o, 32'h1122_3344);
      end
    end
    set_idle();
    #1;
  endtask

  initial begin
    int  holds;
    int  busy;
    bit  err;

    set_idle();
    #3;
    chk("rst_req", {31'b0, bus_req_o}, 32'd0);
    chk("rst_addr", bus_addr_o, 32'd0);
    chk("rst_wdata", bus_wdata_o, 32'd0);
    chk("rst_strb", {28'b0, bus_strb_o}, 32'd0);
    chk("rst_err", {31'b0, bus_err_o}, 32'd0);
    chk("rst_mis", {31'b0, misalign_o}, 32'd0);
    chk("rst_hold", {31'b0, hold_req_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    load(DT_B, 2'd3, 5'd5);
    chk("lb_data", w_reg_data_o, 32'hFFFF_FF80);
    chk("lb_en", {31'b0, w_reg_enable_o}, 32'd1);
    chk("lb_addr", {27'b0, w_reg_addr_o}, 32'd5);
    load(DT_HU, 2'd2, 5'd6);
    chk("lhu_data", w_reg_data_o, 32'h0000_80FF);
    load(DT_H, 2'd2, 5'd6);
    chk("lh_data", w_reg_data_o, 32'hFFFF_80FF);
    load(DT_BU, 2'd1, 5'd6);
    chk("lbu_data", w_reg_data_o, 32'h0000_0012);
    load(DT_H, 2'd0, 5'd6);
    chk("lh0_data", w_reg_data_o, 32'h0000_1234);
    load(DT_W, 2'd0, 5'd7);
    chk("lw_data", w_reg_data_o, 32'h80FF_1234);
    load(DT_B, 2'd0, 5'd0);
    chk("x0_en", {31'b0, w_reg_enable_o}, 32'd0);

    set_idle();
    ex_w_reg_enable_i = 1'b1;
    w_reg_addr_i      = 5'd9;
    ex_w_reg_data_i   = 32'hDEAD_BEEF;
    #1;
    chk("ex_data", w_reg_data_o, 32'hDEAD_BEEF);
    chk("ex_en", {31'b0, w_reg_enable_o}, 32'd1);
    load(DT_BU, 2'd3, 5'd9);
    ex_w_reg_enable_i = 1'b1;
    ex_w_reg_data_i   = 32'hDEAD_BEEF;
    #1;
    chk("both_load_wins", w_reg_data_o, 32'h0000_0080);

    load(DT_W, 2'd2, 5'd7);
    chk("lw_mis_en", {31'b0, w_reg_enable_o}, 32'd0);
    chk("lw_mis_early", {31'b0, misalign_o}, 32'd0);
    cyc();
    chk("lw_mis_pulse", {31'b0, misalign_o}, 32'd1);
    set_idle();
    cyc();
    chk("lw_mis_end", {31'b0, misalign_o}, 32'd0);

    // sb with ack raised after three full BUSY cycles.
    set_idle();
    w_mem_enable_i = 1'b1;
    w_mem_addr_i   = 32'h0000_1001;
    w_mem_data_i   = 32'h0000_00AB;
    data_type_i    = DT_B;
    #1;
    chk("sb_req_idle", {31'b0, bus_req_o}, 32'd0);
    holds = hold_req_o ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (hold_req_o) holds++;
      chk("sb_req_busy", {31'b0, bus_req_o}, 32'd1);
    end
    chk("sb_strb", {28'b0, bus_strb_o}, 32'b0010);
    chk("sb_wdata", bus_wdata_o, 32'hABAB_ABAB);
    chk("sb_addr", bus_addr_o, 32'h0000_1000);
    cyc();
    bus_ack_i = 1'b1;
    #1;
    if (hold_req_o) holds++;
    chk("sb_hold_cnt", holds, 32'd4);
    cyc();
    set_idle();
    #1;
    chk("sb_req_drop", {31'b0, bus_req_o}, 32'd0);
    chk("sb_no_err", {31'b0, bus_err_o}, 32'd0);
    chk("sb_hold_off", {31'b0, hold_req_o}, 32'd0);

    // Aligned sh acked in its first BUSY cycle.
    w_mem_enable_i = 1'b1;
    w_mem_addr_i   = 32'h0000_2002;
    w_mem_data_i   = 32'h0000_C0DE;
    data_type_i    = DT_H;
    cyc();
    chk("sh_strb", {28'b0, bus_strb_o}, 32'b1100);
    chk("sh_wdata", bus_wdata_o, 32'hC0DE_C0DE);
    bus_ack_i = 1'b1;
    #1;
    chk("sh_ack_hold", {31'b0, hold_req_o}, 32'd0);
    cyc();
    set_idle();
    #1;
    chk("sh_req_drop", {31'b0, bus_req_o}, 32'd0);

    run_timeout(32'h0000_3000, busy, err);
    chk("to_err_seen", {31'b0, err}, 32'd1);
    chk("to_busy_cnt", busy, 32'd15);
    chk("to_req_off", {31'b0, bus_req_o}, 32'd0);
    chk("to_hold_off", {31'b0, hold_req_o}, 32'd0);
    cyc();
    chk("to_err_once", {31'b0, bus_err_o}, 32'd0);

    set_idle();
    w_mem_enable_i = 1'b1;
    w_mem_addr_i   = 32'h0000_2003;
    data_type_i    = DT_H;
    #1;
    chk("sh_mis_hold", {31'b0, hold_req_o}, 32'd0);
    cyc();
    chk("sh_mis_req", {31'b0, bus_req_o}, 32'd0);
    chk("sh_mis_pulse", {31'b0, misalign_o}, 32'd1);
    set_idle();
    cyc();
    chk("sh_mis_end", {31'b0, misalign_o}, 32'd0);

    set_idle();
    w_mem_enable_i = 1'b1;
    w_mem_addr_i   = 32'h0000_4000;
    w_mem_data_i   = 32'h5555_AAAA;
    data_type_i    = DT_W;
    cyc();
    chk("rb_req_busy", {31'b0, bus_req_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_req_async", {31'b0, bus_req_o}, 32'd0);
    chk("rb_strb_async", {28'b0, bus_strb_o}, 32'd0);
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("rb_req_after", {31'b0, bus_req_o}, 32'd0);
    chk("rb_err_after", {31'b0, bus_err_o}, 32'd0);
    chk("rb_hold_after", {31'b0, hold_req_o}, 32'd0);
    run_timeout(32'h0000_5004, busy, err);
    chk("rb_to_err", {31'b0, err}, 32'd1);
    chk("rb_to_busy_cnt", busy, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
